rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
Registered, parametrised successor to the combinational 8-to-3 priority encoder. It arbitrates N requesters onto one shared resource and runs in one of two modes: fixed priority or round-robin. Each grant is locked to its owner until the owner drops its request, with optional forced rotation after a maximum hold time. It sits in front of shared datapath resources (mux selects, shared adders) and drives their select lines from grant_idx.

Parameters:
N, 8, number of requesters; legal range 2..64.
MODE, 1, 0 = fixed priority (highest index wins), 1 = round-robin.
MAX_HOLD, 0, maximum consecutive grant cycles per owner; 0 = unlimited.
IDX_W, $clog2(N), width of grant_idx (derived; do not override).
HOLD_W, 8, width of the hold counter; MAX_HOLD must be < 2**HOLD_W.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  arbitration enable; low forces release.
req  input  N  request vector; bit i = requester i.
grant  output  N  one-hot grant, registered; all zero when grant_valid = 0.
grant_idx  output  IDX_W  binary index of the owner; 0 when grant_valid = 0.
grant_valid  output  1  a grant is held.
grant_new  output  1  one-cycle pulse in the first cycle of each new grant, including a handover.

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous and active-low. Under reset: grant = 0, grant_idx = 0, grant_valid = 0, grant_new = 0, rr pointer ptr = 0, hold_cnt = 0, state = IDLE.
- All outputs are registered. A request is seen at edge k and its grant appears after edge k, so latency is 1 cycle.
- States: IDLE (no owner) and GRANT (owner = grant_idx).
- Candidate selection:
  - MODE 0: highest set index in the eligible set.
  - MODE 1: first set index found searching upward from ptr, wrapping N-1 -> 0.
- IDLE:
  - if enable and |req: go to GRANT, owner = selected candidate, grant_new = 1, hold_cnt = 0.
  - otherwise stay in IDLE.
- GRANT, evaluated every cycle:
  - enable = 0: go to IDLE next cycle and clear all outputs. ptr is unchanged.
  - req[owner] = 0 (release): re-arbitrate over req with the owner masked. If a candidate exists, hand over with no idle bubble (grant_new = 1). If none, go to IDLE.
  - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 (expiry): re-arbitrate over req with the owner masked. If another requester exists, preempt and hand over (grant_new = 1). If none, the owner keeps the grant, hold_cnt resets to 0 and grant_new stays 0.
  - otherwise: hold the grant and increment hold_cnt (saturating).
- ptr (MODE 1 only): on every new grant to index i, ptr <= (i+1) mod N. In MODE 0 ptr is unused and stays 0.
- grant_new is high for exactly one cycle per new grant and is never high while the same owner continues.
- Simultaneous release and expiry: treated as a release.
- Simultaneous enable falling and anything else: enable low wins.
- Requests that appear mid-grant are not serviced until release or expiry; there is no preemption by priority.
- Reset asserted mid-grant clears everything immediately (asynchronous). After deassertion the block restarts in IDLE with ptr = 0.
- X or Z on req while enable = 0 must not propagate to the outputs.

Test Plan:
- Reset: N=8, MODE=1; drive rst_n low with req=8'hFF -> grant=0, grant_valid=0, grant_idx=0, grant_new=0; after rst_n rises, next edge -> grant=8'h01, grant_idx=0, grant_new=1.
- Round-robin: MODE=1, req=8'hFF constant; each owner drops its req bit for one cycle after 2 cycles of grant -> grant_idx sequence 0,1,2,...,7,0; each handover has no idle cycle and pulses grant_new=1.
- Fixed priority: MODE=0, req=8'b0010_1100 -> grant_idx=5; drop req[5] -> next cycle grant_idx=3; drop req[3] -> grant_idx=2; drop req[2] -> grant_valid=0 next cycle.
- Hold expiry: MODE=1, MAX_HOLD=4, req=8'h03 held -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. With req=8'h01 only -> owner 0 held continuously, grant_new pulses only once.
- Enable and wrap: MODE=1, owner 7 granted, so ptr=0; deassert enable for 1 cycle -> grant_valid=0 next cycle. Re-enable with req=8'h81 -> grant_idx=0, since the pointer wrapped.
- Reset mid-operation: while owner 3 is held and hold_cnt=2, pulse rst_n low for less than one clock period -> outputs clear immediately without waiting for a clock edge; after release with req=8'h08 -> grant_idx=3 after 1 edge, grant_new=1.

Source files
------------

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// grant_idx drives the select lines of the shared resource.
interface rr_priority_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
);
  logic             enable;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_new;

  modport master (
    output enable, req,
    input  grant, grant_idx, grant_valid, grant_new
  );

  modport slave (
    input  enable, req,
    output grant, grant_idx, grant_valid, grant_new
  );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: fixed priority (highest index) or round-robin,
// grants locked to the owner until release or optional hold-time expiry.
module rr_priority_arbiter #(
  parameter int N        = 8,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N),
  parameter int HOLD_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_priority_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_reg;
  logic [N-1:0]      grant_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              valid_reg;
  logic              new_reg;

  logic [N-1:0]      elig;
  logic [2*N-1:0]    elig_dbl;
  logic [N-1:0]      elig_rot;
  logic [N-1:0]      cand_onehot;
  logic [IDX_W-1:0]  cand;
  logic              cand_found;
  logic              owner_req;
  logic              expire;
  logic              do_take;
  logic              do_clear;
  logic              do_rewind;

  // The current owner is never its own successor; in IDLE grant_reg is zero.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elig
      assign elig[gi]        = bus.req[gi] & ~grant_reg[gi];
      assign cand_onehot[gi] = (cand == IDX_W'(gi));
    end
  endgenerate

  assign elig_dbl  = {elig, elig};
  assign elig_rot  = N'(elig_dbl >> ptr_reg);
  assign owner_req = bus.req[idx_reg];
  assign expire    = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) begin
          cand       = IDX_W'(i);
          cand_found = 1'b1;
        end
      end
    end else begin
      // Walk downward so the smallest offset from ptr is the one that sticks.
      for (int i = N - 1; i >= 0; i--) begin
        if (elig_rot[i]) begin
          cand       = IDX_W'((int'(ptr_reg) + i) % N);
          cand_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    do_take   = 1'b0;
    do_clear  = 1'b0;
    do_rewind = 1'b0;
    if (state_reg == IDLE) begin
      do_take = bus.enable && cand_found;
    end else if (!bus.enable) begin
      do_clear = 1'b1;
    end else if (!owner_req || expire) begin
      if (cand_found) begin
        do_take = 1'b1;
      end else if (!owner_req) begin
        do_clear = 1'b1;
      end else begin
        do_rewind = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      new_reg      <= 1'b0;
    end else if (do_take) begin
      state_reg    <= GRANT;
      grant_reg    <= cand_onehot;
      idx_reg      <= cand;
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b1;
      new_reg      <= 1'b1;
      if (MODE != 0) begin
        ptr_reg <= (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
      end
    end else if (do_clear) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      new_reg      <= 1'b0;
    end else begin
      new_reg <= 1'b0;
      if (do_rewind) begin
        hold_cnt_reg <= '0;
      end else if (state_reg == GRANT && hold_cnt_reg != '1) begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_idx   = idx_reg;
  assign bus.grant_valid = valid_reg;
  assign bus.grant_new   = new_reg;
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: three configurations (round-robin, fixed
// priority, round-robin with MAX_HOLD=4) against directed and random stimulus.
module tb_rr_priority_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter_if #(.N(8)) bus_rr ();
  rr_priority_arbiter_if #(.N(8)) bus_fp ();
  rr_priority_arbiter_if #(.N(8)) bus_mh ();

  rr_priority_arbiter #(.N(8), .MODE(1), .MAX_HOLD(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
  rr_priority_arbiter #(.N(8), .MODE(0), .MAX_HOLD(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));
  rr_priority_arbiter #(.N(8), .MODE(1), .MAX_HOLD(4)) dut_mh (.clk(clk), .rst_n(rst_n), .bus(bus_mh.slave));

  logic [7:0] o_grant [3];
  logic [2:0] o_idx   [3];
  logic       o_valid [3];
  logic       o_new   [3];
  assign o_grant[0] = bus_rr.grant;  assign o_idx[0] = bus_rr.grant_idx;
  assign o_valid[0] = bus_rr.grant_valid; assign o_new[0] = bus_rr.grant_new;
  assign o_grant[1] = bus_fp.grant;  assign o_idx[1] = bus_fp.grant_idx;
  assign o_valid[1] = bus_fp.grant_valid; assign o_new[1] = bus_fp.grant_new;
  assign o_grant[2] = bus_mh.grant;  assign o_idx[2] = bus_mh.grant_idx;
  assign o_valid[2] = bus_mh.grant_valid; assign o_new[2] = bus_mh.grant_new;

  // Reference model: owner (-1 = nobody), rr pointer, cycles held, new-grant flag.
  typedef struct {
    int owner;
    int ptr;
    int hold;
    bit newg;
  } model_t;

  model_t m [3];

  function automatic model_t step(model_t s, int mode, int mh, bit en, logic [7:0] r);
    model_t n = s;
    int c = -1;
    n.newg = 1'b0;
    if (!en) begin
      n.owner = -1;
      n.hold  = 0;
      return n;
    end
    for (int k = 0; k < 8; k++) begin
      int i = (mode == 0) ? 7 - k : (s.ptr + k) % 8;
      if (c < 0 && i != s.owner && r[i] === 1'b1) c = i;
    end
    if (s.owner < 0 || r[s.owner] !== 1'b1 || (mh != 0 && s.hold == mh - 1)) begin
      if (c >= 0) begin
        n.owner = c;
        n.hold  = 0;
        n.newg  = 1'b1;
        if (mode == 1) n.ptr = (c + 1) % 8;
      end else if (s.owner < 0 || r[s.owner] !== 1'b1) begin
        n.owner = -1;
        n.hold  = 0;
      end else begin
        n.hold = 0;
      end
    end else begin
      n.hold = (s.hold < 255) ? s.hold + 1 : 255;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) m[d] <= '{owner: -1, ptr: 0, hold: 0, newg: 1'b0};
    end else begin
      m[0] <= step(m[0], 1, 0, bus_rr.enable, bus_rr.req);
      m[1] <= step(m[1], 0, 0, bus_fp.enable, bus_fp.req);
      m[2] <= step(m[2], 1, 4, bus_mh.enable, bus_mh.req);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_rr.enable = 1'b0; bus_rr.req = '0;
    bus_fp.enable = 1'b0; bus_fp.req = '0;
    bus_mh.enable = 1'b0; bus_mh.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_fp.enable = 1'b0; bus_fp.req = '0;
    bus_mh.enable = 1'b0; bus_mh.req = '0;
    bus_rr.enable = 1'b1; bus_rr.req = 8'hFF;
    tick();
    tick();
    n_checks++;
    if (bus_rr.grant !== 8'h00 || bus_rr.grant_valid !== 1'b0 ||
        bus_rr.grant_idx !== 3'd0 || bus_rr.grant_new !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%h valid=%b idx=%0d new=%b, required 00/0/0/0",
               bus_rr.grant, bus_rr.grant_valid, bus_rr.grant_idx, bus_rr.grant_new);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus_rr.grant !== 8'h01 || bus_rr.grant_idx !== 3'd0 ||
        bus_rr.grant_new !== 1'b1 || bus_rr.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%h idx=%0d new=%b valid=%b, required 01/0/1/1",
               bus_rr.grant, bus_rr.grant_idx, bus_rr.grant_new, bus_rr.grant_valid);
    end
    $display("txn reset: first grant idx=%0d", bus_rr.grant_idx);
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus_rr.enable = 1'b1;
    bus_rr.req    = 8'hFF;
    tick();
    for (int k = 0; k <= 8; k++) begin
      n_checks++;
      if (bus_rr.grant_idx !== 3'(k % 8) || bus_rr.grant_new !== 1'b1 || bus_rr.grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_handover k=%0d: idx=%0d new=%b valid=%b, required %0d/1/1",
                 k, bus_rr.grant_idx, bus_rr.grant_new, bus_rr.grant_valid, k % 8);
      end
      $display("txn rr: owner=%0d", bus_rr.grant_idx);
      if (k == 8) break;
      tick();
      n_checks++;
      if (bus_rr.grant_idx !== 3'(k) || bus_rr.grant_new !== 1'b0 || bus_rr.grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_hold k=%0d: idx=%0d new=%b valid=%b, required %0d/0/1",
                 k, bus_rr.grant_idx, bus_rr.grant_new, bus_rr.grant_valid, k);
      end
      bus_rr.req = 8'hFF & ~(8'h01 << k);
      tick();
      bus_rr.req = 8'hFF;
    end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] reqs [4];
    int         exp_idx [4];
    reqs    = '{8'b0010_1100, 8'b0000_1100, 8'b0000_0100, 8'b0000_0000};
    exp_idx = '{5, 3, 2, -1};
    apply_reset();
    bus_fp.enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus_fp.req = reqs[s];
      tick();
      if (exp_idx[s] >= 0) begin
        n_checks++;
        if (bus_fp.grant_idx !== 3'(exp_idx[s]) || bus_fp.grant !== (8'h01 << exp_idx[s]) ||
            bus_fp.grant_new !== 1'b1) begin
          n_fail++;
          $display("FAIL fixed_prio step=%0d: idx=%0d grant=%h new=%b, required idx %0d new 1",
                   s, bus_fp.grant_idx, bus_fp.grant, bus_fp.grant_new, exp_idx[s]);
        end
      end else begin
        n_checks++;
        if (bus_fp.grant_valid !== 1'b0 || bus_fp.grant !== 8'h00 || bus_fp.grant_idx !== 3'd0) begin
          n_fail++;
          $display("FAIL fixed_prio_idle: valid=%b grant=%h idx=%0d, required 0/00/0",
                   bus_fp.grant_valid, bus_fp.grant, bus_fp.grant_idx);
        end
      end
      $display("txn fixed: req=%b idx=%0d valid=%b", reqs[s], bus_fp.grant_idx, bus_fp.grant_valid);
    end
  endtask

  task automatic test_hold_expiry();
    apply_reset();
    bus_mh.enable = 1'b1;
    bus_mh.req    = 8'h03;
    tick();
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if (bus_mh.grant_idx !== 3'((c / 4) % 2) || bus_mh.grant_new !== (c % 4 == 0) ||
          bus_mh.grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_alternate c=%0d: idx=%0d new=%b, required %0d/%0b",
                 c, bus_mh.grant_idx, bus_mh.grant_new, (c / 4) % 2, (c % 4 == 0));
      end
      tick();
    end
    $display("txn hold: alternating owners checked");
    apply_reset();
    bus_mh.enable = 1'b1;
    bus_mh.req    = 8'h01;
    tick();
    for (int c = 0; c < 13; c++) begin
      n_checks++;
      if (bus_mh.grant_idx !== 3'd0 || bus_mh.grant_valid !== 1'b1 || bus_mh.grant_new !== (c == 0)) begin
        n_fail++;
        $display("FAIL hold_single c=%0d: idx=%0d valid=%b new=%b, required 0/1/%0b",
                 c, bus_mh.grant_idx, bus_mh.grant_valid, bus_mh.grant_new, (c == 0));
      end
      tick();
    end
    $display("txn hold: single owner kept");
  endtask

  task automatic test_enable_wrap();
    apply_reset();
    bus_rr.enable = 1'b1;
    bus_rr.req    = 8'h80;
    tick();
    n_checks++;
    if (bus_rr.grant_idx !== 3'd7 || bus_rr.grant !== 8'h80) begin
      n_fail++;
      $display("FAIL wrap_owner7: idx=%0d grant=%h, required 7/80", bus_rr.grant_idx, bus_rr.grant);
    end
    bus_rr.enable = 1'b0;
    tick();
    n_checks++;
    if (bus_rr.grant_valid !== 1'b0 || bus_rr.grant !== 8'h00 || bus_rr.grant_new !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low: valid=%b grant=%h new=%b, required 0/00/0",
               bus_rr.grant_valid, bus_rr.grant, bus_rr.grant_new);
    end
    bus_rr.enable = 1'b1;
    bus_rr.req    = 8'h81;
    tick();
    n_checks++;
    if (bus_rr.grant_idx !== 3'd0 || bus_rr.grant_new !== 1'b1 || bus_rr.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_regrant: idx=%0d new=%b valid=%b, required 0/1/1",
               bus_rr.grant_idx, bus_rr.grant_new, bus_rr.grant_valid);
    end
    $display("txn wrap: regrant idx=%0d", bus_rr.grant_idx);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus_rr.enable = 1'b1;
    bus_rr.req    = 8'h08;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus_rr.grant_idx !== 3'd3 || bus_rr.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: idx=%0d valid=%b, required 3/1", bus_rr.grant_idx, bus_rr.grant_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_rr.grant !== 8'h00 || bus_rr.grant_valid !== 1'b0 || bus_rr.grant_idx !== 3'd0 ||
        bus_rr.grant_new !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: grant=%h valid=%b idx=%0d new=%b, required 00/0/0/0",
               bus_rr.grant, bus_rr.grant_valid, bus_rr.grant_idx, bus_rr.grant_new);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_rr.grant_idx !== 3'd3 || bus_rr.grant_new !== 1'b1 || bus_rr.grant !== 8'h08) begin
      n_fail++;
      $display("FAIL mid_regrant: idx=%0d new=%b grant=%h, required 3/1/08",
               bus_rr.grant_idx, bus_rr.grant_new, bus_rr.grant);
    end
    $display("txn reset_mid: regrant idx=%0d", bus_rr.grant_idx);
  endtask

  task automatic test_x_disabled();
    apply_reset();
    bus_rr.enable = 1'b0;
    bus_rr.req    = 8'hxx;
    tick();
    tick();
    n_checks++;
    if (bus_rr.grant !== 8'h00 || bus_rr.grant_valid !== 1'b0 || bus_rr.grant_idx !== 3'd0 ||
        bus_rr.grant_new !== 1'b0) begin
      n_fail++;
      $display("FAIL x_disabled: grant=%h valid=%b idx=%h new=%b, required 00/0/0/0",
               bus_rr.grant, bus_rr.grant_valid, bus_rr.grant_idx, bus_rr.grant_new);
    end
    bus_rr.req = 8'h00;
    $display("txn x_disabled: outputs quiet");
  endtask

  task automatic test_random();
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      bus_rr.enable = ($urandom_range(0, 15) != 0);
      bus_fp.enable = ($urandom_range(0, 15) != 0);
      bus_mh.enable = ($urandom_range(0, 15) != 0);
      // Sparse bit flips so grants live for several cycles.
      bus_rr.req = bus_rr.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      bus_fp.req = bus_fp.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      bus_mh.req = bus_mh.req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      tick();
      for (int d = 0; d < 3; d++) begin
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m[d].owner >= 0) ? (8'h01 << m[d].owner) : 8'h00;
        ei = (m[d].owner >= 0) ? 3'(m[d].owner) : 3'd0;
        n_checks++;
        if (o_grant[d] !== eg || o_idx[d] !== ei || o_valid[d] !== (m[d].owner >= 0) ||
            o_new[d] !== m[d].newg) begin
          n_fail++;
          errs++;
          if (errs <= 10)
            $display("FAIL random dut=%0d cyc=%0d: grant=%h idx=%0d valid=%b new=%b, required %h/%0d/%0b/%0b",
                     d, c, o_grant[d], o_idx[d], o_valid[d], o_new[d], eg, ei, (m[d].owner >= 0), m[d].newg);
        end
      end
    end
    $display("txn random: 600 cycles x 3 configurations compared");
  endtask

  initial begin
    bus_rr.enable = 1'b0; bus_rr.req = '0;
    bus_fp.enable = 1'b0; bus_fp.req = '0;
    bus_mh.enable = 1'b0; bus_mh.req = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_hold_expiry();
    test_enable_wrap();
    test_reset_mid();
    test_x_disabled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
